// File: rtl/fifo_rd_drain_if.sv
// Bundles the FIFO read-side signals and the TX parallel handshake.
//
// Handshake semantics:
//   FIFO side: r_inc is a one-cycle pop strobe; it is only ever raised while
//   r_empty is low, and rd_data is the word at the current read address.
//   TX side: tx_data_valid is raised on the cycle a word is presented on
//   tx_p_data and held, with tx_p_data stable, until the first rising edge
//   where tx_busy is sampled high (word accepted) or the ack timeout expires
//   (word dropped). tx_busy high means a frame is in progress.
interface fifo_rd_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  r_empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  r_inc;
    logic [DATA_WIDTH-1:0] tx_p_data;
    logic                  tx_data_valid;
    logic                  tx_busy;

    // The drain block drives the pop strobe and the TX offer.
    modport master (
        input  r_empty,
        input  rd_data,
        input  tx_busy,
        output r_inc,
        output tx_p_data,
        output tx_data_valid
    );

    // The FIFO and TX side of the connection.
    modport slave (
        output r_empty,
        output rd_data,
        output tx_busy,
        input  r_inc,
        input  tx_p_data,
        input  tx_data_valid
    );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-domain drain of an async FIFO: pops one word at a time, offers it to
// the serial TX, waits for the frame to finish, then enforces an idle gap.
// A TX that never raises busy causes the word to be dropped and TO_ERR set.
module fifo_rd_drain #(
    parameter int DATA_WIDTH  = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    input  logic                 en,
    input  logic                 clr_err,
    fifo_rd_drain_if.master      bus,
    output logic [CNT_WIDTH-1:0] byte_cnt,
    output logic                 to_err,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] GAP       = 2'd3;

    localparam int TMO_W = (ACK_TIMEOUT <= 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES <= 1) ? 1 : $clog2(GAP_CYCLES + 1);

    // Terminal counts; GAP_CYCLES==0 never enters GAP so its value is moot there.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    // State after a finished or dropped word: skip GAP entirely when no gap is wanted.
    localparam logic [1:0] POST_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

    logic [1:0]            state;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_valid_q;

    // Pop only from IDLE; r_empty gating makes a pop on empty impossible.
    assign bus.r_inc         = (state == IDLE) & en & ~bus.r_empty & ~r_rst;
    assign bus.tx_p_data     = tx_data_q;
    assign bus.tx_data_valid = tx_valid_q;
    assign dbg_state         = state;

    // Drain FSM with its timeout/gap counters, byte counter and sticky error.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            byte_cnt   <= '0;
            to_err     <= 1'b0;
        end else begin
            // Clear first so a timeout on the same edge overrides it.
            if (clr_err) begin
                to_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en && !bus.r_empty) begin
                        tx_data_q  <= bus.rd_data;
                        tx_valid_q <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= SEND;
                    end else begin
                        tx_valid_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (bus.tx_busy) begin
                        tx_valid_q <= 1'b0;
                        byte_cnt   <= byte_cnt + 1'b1;
                        state      <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tx_valid_q <= 1'b0;
                        to_err     <= 1'b1;
                        gap_cnt    <= '0;
                        state      <= POST_STATE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        gap_cnt <= '0;
                        state   <= POST_STATE;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: FIFO queue model, TX model with fixed busy timing,
// scoreboard monitor comparing accepted words against an expected queue.
module tb_fifo_rd_drain;

    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int ACK = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr_err;
    logic [CW-1:0] byte_cnt;
    logic          to_err;
    logic [1:0]    dbg_state;

    fifo_rd_drain_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_drain #(
        .DATA_WIDTH (DW),
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(ACK),
        .CNT_WIDTH  (CW)
    ) dut (
        .r_clk    (clk),
        .r_rst    (rst),
        .en       (en),
        .clr_err  (clr_err),
        .bus      (bus),
        .byte_cnt (byte_cnt),
        .to_err   (to_err),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int pop_count = 0;
    int acc_run = 0;
    bit busy_en = 1'b1;
    bit tmo_check_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        bus.r_empty = (fifo_q.size() == 0);
        bus.rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [DW-1:0] w, input bit expect_accept);
        fifo_q.push_back(w);
        if (expect_accept) exp_q.push_back(w);
        fifo_refresh();
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Waits until the block is idle with nothing queued and the TX quiet.
    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (dbg_state == 2'd0) && (fifo_q.size() == 0) &&
                   !bus.tx_data_valid && !bus.tx_busy;
        end
        chk({name, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!bus.tx_data_valid && n < budget) begin
            sync();
            n++;
        end
        chk({name, "_valid_seen"}, 32'(bus.tx_data_valid), 32'd1);
    endtask

    task automatic do_reset();
        sync();
        rst = 1'b1;
        sync();
        chk("rst_valid", 32'(bus.tx_data_valid), 32'd0);
        chk("rst_data", 32'(bus.tx_p_data), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        chk("rst_to_err", 32'(to_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        sync();
        rst = 1'b0;
    endtask

    // FIFO model: a pop seen mid-cycle is applied just after the next edge.
    initial begin
        bit p;
        forever begin
            @(negedge clk);
            p = bus.r_inc;
            if (p) pop_count++;
            @(posedge clk);
            #1;
            if (p && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                fifo_refresh();
            end
        end
    end

    // TX model: busy rises 2 cycles after valid is seen and lasts 10 cycles.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_data_valid && busy_en && !rst) begin
                repeat (2) @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    // Monitor: scoreboard on acceptance, offer-length check on drops, pop-on-empty.
    initial begin
        int run = 0;
        bit accepted = 1'b0;
        forever begin
            @(negedge clk);
            chk("pop_on_empty", 32'(bus.r_inc & bus.r_empty), 32'd0);
            if (rst) begin
                run = 0;
                accepted = 1'b0;
            end else if (bus.tx_data_valid) begin
                run++;
                if (bus.tx_busy && !accepted) begin
                    accepted = 1'b1;
                    acc_run = run;
                    if (exp_q.size() == 0) chk("unexpected_word", 32'(bus.tx_p_data), 32'hFFFF_FFFF);
                    else chk("tx_word", 32'(bus.tx_p_data), 32'(exp_q.pop_front()));
                end
            end else if (run > 0) begin
                if (!accepted && tmo_check_en) chk("tmo_valid_len", 32'(run), 32'(ACK));
                run = 0;
                accepted = 1'b0;
            end
        end
    end

    // Directed test sequence
    initial begin
        int n;
        int gap_n;
        int pop_base;
        rst = 1'b1;
        en = 1'b1;
        clr_err = 1'b0;
        fifo_q.delete();
        fifo_refresh();
        push_word(8'hA5, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_r_inc", 32'(bus.r_inc), 32'd0);
        chk("rst_valid_init", 32'(bus.tx_data_valid), 32'd0);
        chk("rst_cnt_init", 32'(byte_cnt), 32'd0);
        sync();
        rst = 1'b0;

        // Test 1: single word, then pop spacing after busy falls
        wait_drain(100, "t1");
        chk("t1_pops", 32'(pop_count), 32'd1);
        chk("t1_byte_cnt", 32'(byte_cnt), 32'd1);
        chk("t1_valid_len", 32'(acc_run), 32'd3);
        chk("t1_to_err", 32'(to_err), 32'd0);
        sync();
        push_word(8'h5A, 1'b1);
        push_word(8'hC3, 1'b1);
        n = 0;
        while (!bus.tx_busy && n < 100) begin @(negedge clk); n++; end
        while (bus.tx_busy && n < 200) begin @(negedge clk); n++; end
        gap_n = 0;
        while (!bus.r_inc && gap_n < 50) begin @(negedge clk); gap_n++; end
        chk("t1_pop_gap", 32'(gap_n), 32'd3);
        wait_drain(100, "t1b");
        chk("t1b_byte_cnt", 32'(byte_cnt), 32'd3);
        chk("t1b_pops", 32'(pop_count), 32'd3);

        // Test 2: eight words back to back
        do_reset();
        pop_base = pop_count;
        sync();
        for (int i = 1; i <= 8; i++) push_word(DW'(i), 1'b1);
        wait_drain(400, "t2");
        chk("t2_pops", 32'(pop_count - pop_base), 32'd8);
        chk("t2_byte_cnt", 32'(byte_cnt), 32'd8);

        // Test 4: enable dropped during WAIT_DONE with three words queued
        do_reset();
        pop_base = pop_count;
        sync();
        push_word(8'h10, 1'b1);
        push_word(8'h20, 1'b1);
        push_word(8'h30, 1'b1);
        n = 0;
        while (dbg_state != 2'd2 && n < 50) begin @(negedge clk); n++; end
        chk("t4_in_wait_done", 32'(dbg_state), 32'd2);
        sync();
        en = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4_pops_held", 32'(pop_count - pop_base), 32'd1);
        chk("t4_byte_cnt_held", 32'(byte_cnt), 32'd1);
        chk("t4_fifo_left", 32'(fifo_q.size()), 32'd2);
        chk("t4_state_idle", 32'(dbg_state), 32'd0);
        sync();
        en = 1'b1;
        wait_drain(200, "t4");
        chk("t4_byte_cnt", 32'(byte_cnt), 32'd3);

        // Test 3: handshake timeout, recovery, clear, clear-vs-set
        do_reset();
        busy_en = 1'b0;
        sync();
        push_word(8'h33, 1'b0);
        wait_drain(50, "t3_drop");
        chk("t3_to_err_set", 32'(to_err), 32'd1);
        chk("t3_byte_cnt_drop", 32'(byte_cnt), 32'd0);
        busy_en = 1'b1;
        sync();
        push_word(8'h44, 1'b1);
        wait_drain(100, "t3_next");
        chk("t3_byte_cnt_next", 32'(byte_cnt), 32'd1);
        chk("t3_to_err_sticky", 32'(to_err), 32'd1);
        sync();
        clr_err = 1'b1;
        sync();
        clr_err = 1'b0;
        chk("t3_to_err_clr", 32'(to_err), 32'd0);
        busy_en = 1'b0;
        sync();
        push_word(8'h55, 1'b0);
        wait_valid(10, "t3_coinc");
        repeat (3) @(posedge clk);
        #1 clr_err = 1'b1;
        sync();
        clr_err = 1'b0;
        chk("t3_set_wins", 32'(to_err), 32'd1);
        chk("t3_state_gap", 32'(dbg_state), 32'd3);
        wait_drain(50, "t3_coinc");

        // Test 5: reset while offering a word
        tmo_check_en = 1'b0;
        sync();
        push_word(8'h66, 1'b0);
        push_word(8'h77, 1'b0);
        wait_valid(10, "t5");
        rst = 1'b1;
        sync();
        chk("t5_valid", 32'(bus.tx_data_valid), 32'd0);
        chk("t5_byte_cnt", 32'(byte_cnt), 32'd0);
        chk("t5_to_err", 32'(to_err), 32'd0);
        chk("t5_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        chk("t5_r_inc_in_rst", 32'(bus.r_inc), 32'd0);
        busy_en = 1'b1;
        exp_q.push_back(8'h77);
        sync();
        rst = 1'b0;
        wait_drain(100, "t5");
        tmo_check_en = 1'b1;
        chk("t5_byte_cnt_after", 32'(byte_cnt), 32'd1);

        // Test 6: seventeen words wrap the 4-bit counter
        do_reset();
        sync();
        for (int i = 0; i < 17; i++) push_word(DW'(i * 3 + 1), 1'b1);
        wait_drain(17 * 25, "t6");
        chk("t6_byte_cnt_wrap", 32'(byte_cnt), 32'd1);
        chk("t6_to_err", 32'(to_err), 32'd0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
